// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register with hazard control FSM: load-use stall, memory wait and branch flush.
// Optional STALL_COUNT_EN adds a saturating counter of cycles in which the fetch PC is frozen.
module if_id_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        fetch_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic [31:0] instructionToDecoder,
    output logic        id_valid,
    output logic        pc_write,
    output logic        bubble_to_ex,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [4:0]  id_rs, id_rt;
    logic        hazard_lu;

    assign id_rs = instr_q[25:21];
    assign id_rt = instr_q[20:16];

    // The cycle after a load-use stall the load has left EX, so re-detecting would double-stall.
    assign hazard_lu = valid_q && ex_mem_read && (ex_rd != 5'd0)
                       && ((ex_rd == id_rs) || (ex_rd == id_rt))
                       && (state_q != LU_STALL);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = RUN;
        instr_d      = instruction;
        valid_d      = fetch_valid;
        pc_write     = 1'b1;
        bubble_to_ex = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b1;
            bubble_to_ex = 1'b0;
        end else if (branch_taken) begin
            bubble_to_ex = 1'b1;
            instr_d      = 32'h0;
            valid_d      = 1'b0;
            state_d      = FLUSH;
        end else if (mem_busy) begin
            pc_write = 1'b0;
            instr_d  = instr_q;
            valid_d  = valid_q;
            state_d  = MEM_WAIT;
        end else if (hazard_lu) begin
            pc_write     = 1'b0;
            bubble_to_ex = 1'b1;
            instr_d      = instr_q;
            valid_d      = valid_q;
            state_d      = LU_STALL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 16'h0;
        end else if (!pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0;
`endif

    assign instructionToDecoder = instr_q;
    assign id_valid             = valid_q;
    assign ctrl_state           = state_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Scoreboard bench for if_id_ctrl: stimulus pushes expected per-cycle responses, a monitor pops and compares.
module tb_if_id_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        fetch_valid, ex_mem_read, branch_taken, mem_busy;
    logic [4:0]  ex_rd;
    logic [31:0] instructionToDecoder;
    logic        id_valid, pc_write, bubble_to_ex;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        pcw;
        logic        bub;
        logic [31:0] instr;
        logic        vld;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: what the decode stage holds and which event last happened.
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    int          m_state = 0;   // 0 run, 1 load-use stall, 2 memory wait, 3 flush
    logic [15:0] m_cnt   = 16'h0;

    if_id_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instruction          (instruction),
        .fetch_valid          (fetch_valid),
        .ex_mem_read          (ex_mem_read),
        .ex_rd                (ex_rd),
        .branch_taken         (branch_taken),
        .mem_busy             (mem_busy),
        .instructionToDecoder (instructionToDecoder),
        .id_valid             (id_valid),
        .pc_write             (pc_write),
        .bubble_to_ex         (bubble_to_ex),
        .ctrl_state           (ctrl_state),
        .stall_count          (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, predict the response, hand it to the monitor, then advance to next cycle.
    task automatic drive(input logic [31:0] ins, input logic fv, input logic mr,
                         input logic [4:0] rd, input logic br, input logic mb);
        exp_t e;
        logic lu;
        instruction  = ins;
        fetch_valid  = fv;
        ex_mem_read  = mr;
        ex_rd        = rd;
        branch_taken = br;
        mem_busy     = mb;
        lu = m_valid && mr && (rd != 5'd0)
             && ((rd == m_instr[25:21]) || (rd == m_instr[20:16])) && (m_state != 1);
        if (br) begin
            e.pcw = 1'b1; e.bub = 1'b1;
            m_instr = 32'h0; m_valid = 1'b0; m_state = 3;
        end else if (mb) begin
            e.pcw = 1'b0; e.bub = 1'b0; m_state = 2;
        end else if (lu) begin
            e.pcw = 1'b0; e.bub = 1'b1; m_state = 1;
        end else begin
            e.pcw = 1'b1; e.bub = 1'b0;
            m_instr = ins; m_valid = fv; m_state = 0;
        end
`ifdef STALL_COUNT_EN
        if (!e.pcw && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        e.instr = m_instr;
        e.vld   = m_valid;
        e.st    = 2'(m_state);
        e.cnt   = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pc_write", {31'h0, pc_write}, {31'h0, e.pcw});
                check("bubble_to_ex", {31'h0, bubble_to_ex}, {31'h0, e.bub});
                @(posedge clk);
                #1;
                check("instructionToDecoder", instructionToDecoder, e.instr);
                check("id_valid", {31'h0, id_valid}, {31'h0, e.vld});
                check("ctrl_state", {30'h0, ctrl_state}, {30'h0, e.st});
                check("stall_count", {16'h0, stall_count}, {16'h0, e.cnt});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, instructionToDecoder, 32'h0);
        check({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        check({tag, "_state"}, {30'h0, ctrl_state}, 32'h0);
        check({tag, "_count"}, {16'h0, stall_count}, 32'h0);
        check({tag, "_pc_write"}, {31'h0, pc_write}, 32'h1);
        check({tag, "_bubble"}, {31'h0, bubble_to_ex}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        instruction = 32'h0; fetch_valid = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 5'd0; branch_taken = 1'b1; mem_busy = 1'b0;
        #1;
        check_reset_outputs("reset");
        branch_taken = 1'b0;
        #11 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Clean two-instruction stream.
        drive(32'h8C220004, 1, 0, 5'd0, 0, 0);
        drive(32'h00430820, 1, 0, 5'd0, 0, 0);
        // Load-use on rs=2: one stall, then suppressed detection lets the next word in.
        drive(32'h00000000, 1, 1, 5'd2, 0, 0);
        drive(32'h00000000, 1, 1, 5'd2, 0, 0);
        // Same dependency through ex_rd=0 never stalls.
        drive(32'h00430820, 1, 0, 5'd0, 0, 0);
        drive(32'h01000000, 1, 1, 5'd0, 0, 0);
        // Branch flush, then fresh fetch.
        drive(32'h00430820, 1, 0, 5'd0, 0, 0);
        drive(32'hDEADBEEF, 1, 0, 5'd0, 1, 0);
        drive(32'h12345678, 1, 0, 5'd0, 0, 0);
        // Memory wait with load-use pending, branch overriding on the second cycle.
        drive(32'h00430820, 1, 0, 5'd0, 0, 0);
        drive(32'hAAAA0000, 1, 1, 5'd2, 0, 1);
        drive(32'hAAAA0000, 1, 1, 5'd2, 1, 1);
        drive(32'hAAAA0000, 1, 1, 5'd2, 0, 1);
        drive(32'hBBBB0000, 1, 0, 5'd0, 0, 0);

        // Asynchronous reset while in the load-use stall.
        drive(32'h00430820, 1, 0, 5'd0, 0, 0);
        drive(32'h11111111, 1, 1, 5'd2, 0, 0);
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
        check("drain_before_reset", sb_q.size(), 0);
        #1;
        rst_n = 1'b0;
        branch_taken = 1'b1;
        mem_busy = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        #2;
        branch_taken = 1'b0;
        mem_busy = 1'b0;
        rst_n = 1'b1;
        m_instr = 32'h0; m_valid = 1'b0; m_state = 0; m_cnt = 16'h0;
        @(posedge clk);
        #2;
        drive(32'h00430820, 1, 1, 5'd2, 0, 0);
        drive(32'h22222222, 1, 0, 5'd0, 0, 0);

        // Randomized traffic with a narrow register range so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            drive(ins, ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_ctrl.md
IF_ID_CTRL -- requirements
Module: if_id_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port instruction  in  32  word from fetch stage.
REQ-004 SHALL have port fetch_valid  in  1  instruction is a real fetch.
REQ-005 SHALL have port ex_mem_read  in  1  instruction in EX is a load.
REQ-006 SHALL have port ex_rd  in  5  destination register of EX instruction.
REQ-007 SHALL have port branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-008 SHALL have port mem_busy  in  1  data memory stall request.
REQ-009 SHALL have port instructionToDecoder  out  32  held IF/ID instruction.
REQ-010 SHALL have port id_valid  out  1  instructionToDecoder is valid.
REQ-011 SHALL have port pc_write  out  1  fetch PC may advance.
REQ-012 SHALL have port bubble_to_ex  out  1  ID/EX control must be zeroed this cycle.
REQ-013 SHALL have port ctrl_state  out  2  current FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3).
REQ-014 SHALL have port stall_count  out  16  saturating stall-cycle counter.

Function
REQ-015 SHALL decode id_rs = instructionToDecoder[25:21], id_rt = instructionToDecoder[20:16].
REQ-016 SHALL flag hazard_lu when id_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt) & state!=LU_STALL.
REQ-017 SHALL apply priority per cycle: branch_taken > mem_busy > hazard_lu > normal.
REQ-018 SHALL drive pc_write, bubble_to_ex combinationally from current inputs and state (same-cycle effect).
REQ-019 Normal: pc_write=1, bubble_to_ex=0; on edge load instruction, id_valid<=fetch_valid; next state RUN.
REQ-020 branch_taken: pc_write=1, bubble_to_ex=1; on edge load 32'h0, id_valid<=0; next state FLUSH.
REQ-021 mem_busy (no branch): pc_write=0, bubble_to_ex=0; IF/ID holds; next state MEM_WAIT.
REQ-022 hazard_lu (no branch, no mem_busy): pc_write=0, bubble_to_ex=1; IF/ID holds; next state LU_STALL.
REQ-023 State LU_STALL or FLUSH SHALL last exactly one cycle unless a higher-priority event occurs; MEM_WAIT persists while mem_busy=1.
REQ-024 In LU_STALL, load-use detection SHALL be suppressed; a second consecutive stall for the same load SHALL NOT occur.
REQ-025 branch_taken during MEM_WAIT or LU_STALL SHALL override and take the FLUSH path that cycle.
REQ-026 ex_rd=0 SHALL never cause a stall.
REQ-027 instructionToDecoder/id_valid SHALL change only on rising clk or reset.

Reset
REQ-028 rst_n=0 SHALL immediately force instructionToDecoder=0, id_valid=0, state RUN, stall_count=0, independent of clk.
REQ-029 During reset pc_write=1, bubble_to_ex=0; first capture on first rising edge after rst_n rises.
REQ-030 Reset mid-stall or mid-flush SHALL abandon the event; no residual stall after release.

Configuration
REQ-031 With STALL_COUNT_EN defined, stall_count SHALL increment by 1 on each edge where pc_write=0, saturating at 16'hFFFF.
REQ-032 Without STALL_COUNT_EN, stall_count SHALL be constant 0 and no counter flops SHALL exist; all other behaviour identical.

Verification
REQ-033 Stream 0x8C220004, 0x00430820 with fetch_valid=1, no hazards -> appear on instructionToDecoder on consecutive edges, id_valid=1, pc_write=1 throughout.
REQ-034 ID holds 0x00430820 (rs=2), ex_mem_read=1, ex_rd=2 -> pc_write=0, bubble_to_ex=1 for exactly one cycle, ctrl_state=1 next, then RUN; stall_count 0->1 (EN defined).
REQ-035 Same as REQ-034 with ex_rd=0 -> no stall, pc_write=1.
REQ-036 branch_taken=1 one cycle -> bubble_to_ex=1 that cycle; next edge instructionToDecoder=0, id_valid=0, ctrl_state=3; following edge RUN with new fetch.
REQ-037 mem_busy=1 for 3 cycles with load-use pending and branch_taken on cycle 2 -> cycle 1 MEM_WAIT hold, cycle 2 FLUSH path (pc_write=1, bubble_to_ex=1); stall_count counts only cycles where pc_write=0.
REQ-038 rst_n low asynchronously mid-LU_STALL -> outputs reset values before next clk edge; after release, normal capture with no stall.
